// File: rtl/alu_mult_seq.sv
// Sequential 32x32 -> 32 shift-and-add multiplier that drives an external ALU, one operation per busy cycle.
// Optional build macro MULT_EARLY_EXIT_EN: finish as soon as the shifted multiplier reaches zero.
module alu_mult_seq (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [1:0]  ALUOP,
    output logic [31:0] portA,
    output logic [31:0] portB,
    input  logic [31:0] out_port,
    input  logic        zero,
    input  logic        neg,
    input  logic        ovf
);
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SLL = 2'd1;
    localparam logic [1:0] ALU_SRL = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHL, S_SHR, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_acc;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [5:0]  r_iter;
    logic [31:0] r_result;
    logic        w_last;
    logic        w_unused_flags;

    // The iteration counter is incremented in the same cycle, so 31 here means the 32nd SHR.
`ifdef MULT_EARLY_EXIT_EN
    assign w_last         = zero || (r_iter == 6'd31);
    assign w_unused_flags = neg ^ ovf;
`else
    assign w_last         = (r_iter == 6'd31);
    assign w_unused_flags = neg ^ ovf ^ zero;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ADD;
            S_ADD:   w_next = S_SHL;
            S_SHL:   w_next = S_SHR;
            S_SHR:   w_next = w_last ? S_DONE : S_ADD;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ALUOP = ALU_ADD;
        portA = 32'd0;
        portB = 32'd0;
        busy  = (r_state != S_IDLE);
        done  = (r_state == S_DONE);
        case (r_state)
            S_ADD: begin
                portA = r_acc;
                portB = r_mplier[0] ? r_mcand : 32'd0;
            end
            S_SHL: begin
                ALUOP = ALU_SLL;
                portA = r_mcand;
                portB = 32'd1;
            end
            S_SHR: begin
                ALUOP = ALU_SRL;
                portA = r_mplier;
                portB = 32'd1;
            end
            default: ;
        endcase
    end

    // Datapath registers only ever load from the ALU result or the captured operands.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_acc    <= 32'd0;
            r_mcand  <= 32'd0;
            r_mplier <= 32'd0;
            r_iter   <= 6'd0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= op_a;
                        r_mplier <= op_b;
                        r_acc    <= 32'd0;
                        r_iter   <= 6'd0;
                    end
                end
                S_ADD: r_acc <= out_port;
                S_SHL: r_mcand <= out_port;
                S_SHR: begin
                    r_mplier <= out_port;
                    r_iter   <= r_iter + 6'd1;
                    if (w_last) r_result <= r_acc;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
endmodule
